sram_bus_arbiter: RTL and testbench

Shares one sram-like memory port between the IF-stage instruction fetch port and the MEM-stage data port. Arbitrates requests with data priority, holds the granted request stable on the bus until `bus_addr_ok`, and routes each in-order `bus_data_ok` back to its issuer. Sits between the pipeline (`inst_sram_*` / `data_sram_*`) and the AXI bridge.

---
 rtl/cpu_bus_pkg.sv | 23 ++
 rtl/req_tag_fifo.sv | 61 ++++++
 rtl/sram_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the pipeline-to-bridge sram-like bus arbiter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Issuer of an accepted transaction, and whether its response is swallowed.
  typedef struct packed {
    logic src;
    logic drop;
  } tag_t;

endpackage

// File: rtl/req_tag_fifo.sv
// In-order tag queue for accepted bus transactions; a zero-latency head feeds the response demux.
// Pushes while full and pops while empty are ignored; drop_inst marks every queued fetch tag.
module req_tag_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  input  logic drop_inst,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tag_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Broadcast first; a same-cycle push carries its own drop bit and overrides.
      if (drop_inst) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_mem[i].src == SRC_INST) r_mem[i].drop <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr] <= push_tag;
        r_wr        <= ptr_next(r_wr);
      end
      if (w_pop) r_rd <= ptr_next(r_rd);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between fetch and data with data priority and no preemption.
// Zero-cycle request and response paths; responses are routed in order via the tag queue.
module sram_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  input  logic        flush
);

  arb_state_t r_state;
  logic       r_flush_pending;
  logic       w_gsrc;
  logic       w_bus_req;
  logic       w_accept;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  tag_t       w_head;
  tag_t       w_push_tag;

  // Request gated by resetn so every output is quiet while reset is held.
  always_comb begin
    w_gsrc    = SRC_INST;
    w_bus_req = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (!w_full) begin
          if (data_req) begin
            w_gsrc    = SRC_DATA;
            w_bus_req = 1'b1;
          end else if (inst_req) begin
            w_bus_req = 1'b1;
          end
        end
      end
      ARB_INST: w_bus_req = inst_req;
      ARB_DATA: begin
        w_gsrc    = SRC_DATA;
        w_bus_req = data_req;
      end
      default: ;
    endcase
    w_bus_req = w_bus_req & resetn;
  end

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (w_bus_req) begin
      if (w_gsrc == SRC_DATA) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_wstrb = inst_wstrb;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  assign bus_req      = w_bus_req;
  assign w_accept     = w_bus_req & bus_addr_ok;
  assign inst_addr_ok = w_accept & (w_gsrc == SRC_INST);
  assign data_addr_ok = w_accept & (w_gsrc == SRC_DATA);

  assign w_push_tag.src  = w_gsrc;
  assign w_push_tag.drop = (w_gsrc == SRC_INST) & (flush | r_flush_pending);

  assign w_pop        = bus_data_ok & ~w_empty;
  assign inst_data_ok = w_pop & (w_head.src == SRC_INST) & ~w_head.drop;
  assign data_data_ok = w_pop & (w_head.src == SRC_DATA) & ~w_head.drop;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;

  // A flushed fetch still stays on the bus until accepted; only its response is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ARB_IDLE;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_accept)
        r_flush_pending <= 1'b0;
      else if (flush && w_bus_req && (w_gsrc == SRC_INST))
        r_flush_pending <= 1'b1;
      unique case (r_state)
        ARB_IDLE: if (w_bus_req && !bus_addr_ok)
                    r_state <= (w_gsrc == SRC_DATA) ? ARB_DATA : ARB_INST;
        ARB_INST, ARB_DATA: if (w_accept) r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  req_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_accept),
    .push_tag  (w_push_tag),
    .pop       (w_pop),
    .drop_inst (flush),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed per-cycle vector table plus a hand-written mid-transaction reset sequence.
module tb_sram_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam logic [31:0] IADDR = 32'h1c00_0000;
  localparam logic [31:0] DADDR = 32'h1c01_0004;
  localparam logic [31:0] DWDAT = 32'hdead_beef;
  localparam logic [3:0]  DSTRB = 4'b0011;
  localparam int          NV    = 35;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, bus_addr_ok, bus_data_ok, flush;
  logic [31:0] bus_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int outst = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(1'b0), .inst_size(SIZE_W), .inst_wstrb(4'b0000),
    .inst_addr(IADDR), .inst_wdata(32'h0),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(1'b1), .data_size(SIZE_H), .data_wstrb(DSTRB),
    .data_addr(DADDR), .data_wdata(DWDAT),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .flush(flush)
  );

  // Bench-side occupancy from the bus handshake; a response with nothing outstanding is a violation.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) outst = 0;
    else begin
      if (bus_data_ok) begin
        if (outst == 0) viol++;
        else outst--;
      end
      if (bus_req && bus_addr_ok) outst++;
    end
  end

  typedef struct {
    logic ireq, dreq, baok, bdok, fl;
    logic [31:0] rd;
    logic breq;
    logic [1:0] sel;   // 0 idle bus, 1 fetch fields, 2 data fields
    logic iaok, daok, idok, ddok;
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] bus_exp(input logic [1:0] sel);
    case (sel)
      2'd1:    return {1'b0, SIZE_W, 4'b0000, IADDR, 32'h0};
      2'd2:    return {1'b1, SIZE_H, DSTRB, DADDR, DWDAT};
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic ir, input logic dr, input logic ao, input logic dok,
                       input logic fl, input logic [31:0] rd);
    @(negedge clk);
    inst_req = ir; data_req = dr; bus_addr_ok = ao; bus_data_ok = dok; flush = fl; bus_rdata = rd;
    #1;
  endtask

  initial begin
    //        ireq dreq baok bdok fl  rdata           breq sel  iaok daok idok ddok
    vt[0]  = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 0, 32'h0280_0000,  0, 2'd0, 0, 0, 1, 0};
    vt[4]  = '{1, 1, 1, 0, 0, 32'h0,          1, 2'd2, 0, 1, 0, 0};
    vt[5]  = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 32'h1111_2222,  0, 2'd0, 0, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 1, 0, 32'h3333_4444,  0, 2'd0, 0, 0, 1, 0};
    vt[8]  = '{1, 0, 0, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0};
    vt[9]  = '{1, 1, 0, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0};
    vt[10] = '{1, 1, 0, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0};
    vt[11] = '{1, 1, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[12] = '{0, 1, 1, 0, 0, 32'h0,          1, 2'd2, 0, 1, 0, 0};
    vt[13] = '{0, 0, 0, 1, 0, 32'haaaa_0001,  0, 2'd0, 0, 0, 1, 0};
    vt[14] = '{0, 0, 0, 1, 0, 32'hbbbb_0002,  0, 2'd0, 0, 0, 0, 1};
    vt[15] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[16] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[17] = '{1, 0, 1, 0, 0, 32'h0,          0, 2'd0, 0, 0, 0, 0};
    vt[18] = '{1, 0, 1, 1, 0, 32'hcccc_0003,  0, 2'd0, 0, 0, 1, 0};
    vt[19] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[20] = '{0, 0, 0, 1, 0, 32'hdddd_0004,  0, 2'd0, 0, 0, 1, 0};
    vt[21] = '{0, 0, 0, 1, 0, 32'heeee_0005,  0, 2'd0, 0, 0, 1, 0};
    vt[22] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[23] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[24] = '{0, 0, 0, 0, 1, 32'h0,          0, 2'd0, 0, 0, 0, 0};
    vt[25] = '{0, 0, 0, 1, 0, 32'h1234_0006,  0, 2'd0, 0, 0, 0, 0};
    vt[26] = '{0, 0, 0, 1, 0, 32'h1234_0007,  0, 2'd0, 0, 0, 0, 0};
    vt[27] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[28] = '{0, 0, 0, 1, 0, 32'hffff_0008,  0, 2'd0, 0, 0, 1, 0};
    vt[29] = '{1, 0, 0, 0, 0, 32'h0,          1, 2'd1, 0, 0, 0, 0};
    vt[30] = '{1, 0, 0, 0, 1, 32'h0,          1, 2'd1, 0, 0, 0, 0};
    vt[31] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[32] = '{0, 0, 0, 1, 0, 32'h5555_0009,  0, 2'd0, 0, 0, 0, 0};
    vt[33] = '{1, 0, 1, 0, 0, 32'h0,          1, 2'd1, 1, 0, 0, 0};
    vt[34] = '{0, 0, 0, 1, 0, 32'h7777_000a,  0, 2'd0, 0, 0, 1, 0};

    // Reset held with both requests pending: outputs must stay quiet.
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    flush = 1'b0; bus_rdata = 32'h9999_9999;
    #1;
    chk("rst_bus_req", 71'(bus_req), 71'(0));
    chk("rst_bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, '0);
    chk("rst_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
    chk("rst_data_ok", 71'({inst_data_ok, data_data_ok}), 71'(0));
    @(negedge clk);
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].ireq, vt[i].dreq, vt[i].baok, vt[i].bdok, vt[i].fl, vt[i].rd);
      chk($sformatf("v%0d_bus_req", i), 71'(bus_req), 71'(vt[i].breq));
      chk($sformatf("v%0d_bus_fields", i), {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
          bus_exp(vt[i].sel));
      chk($sformatf("v%0d_addr_ok", i), 71'({inst_addr_ok, data_addr_ok}),
          71'({vt[i].iaok, vt[i].daok}));
      chk($sformatf("v%0d_data_ok", i), 71'({inst_data_ok, data_data_ok}),
          71'({vt[i].idok, vt[i].ddok}));
      chk($sformatf("v%0d_inst_rdata", i), 71'(inst_rdata), 71'(vt[i].idok ? vt[i].rd : 32'h0));
      chk($sformatf("v%0d_data_rdata", i), 71'(data_rdata), 71'(vt[i].ddok ? vt[i].rd : 32'h0));
    end

    // Data store accepted, then reset asserted while it is still outstanding.
    drive(0, 1, 1, 0, 0, 32'h0);
    chk("mid_data_accept", 71'(data_addr_ok), 71'(1));
    @(negedge clk);
    resetn = 1'b0;
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h4242_4242;
    #1;
    chk("mid_rst_bus_req", 71'(bus_req), 71'(0));
    chk("mid_rst_bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, '0);
    chk("mid_rst_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
    chk("mid_rst_data_ok", 71'({inst_data_ok, data_data_ok, data_rdata}), 71'(0));
    @(negedge clk);
    resetn = 1'b1;
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    drive(0, 0, 0, 1, 0, 32'h0000_0055);
    chk("post_rst_stray_rsp", 71'({inst_data_ok, data_data_ok}), 71'(0));
    drive(1, 0, 1, 0, 0, 32'h0);
    chk("post_rst_fetch_aok", 71'(inst_addr_ok), 71'(1));
    chk("post_rst_fetch_addr", 71'(bus_addr), 71'(IADDR));
    drive(0, 0, 0, 1, 0, 32'h0000_0066);
    chk("post_rst_fetch_dok", 71'({inst_data_ok, inst_rdata}), 71'({1'b1, 32'h0000_0066}));
    drive(0, 0, 0, 0, 0, 32'h0);
    chk("empty_rsp_violations", 71'(viol), 71'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
